// File: rtl/ysyx_2022040010_div.sv
// Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and their word forms.
// One quotient bit per cycle; results are returned through a valid/ready handshake.
module ysyx_2022040010_div (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_32,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e      state_q, state_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] dsr_q, dsr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        w32_q, w32_d;

    // Operand preparation at the active width
    logic [63:0] a_ext, b_ext, a_mag, b_mag, a_sext32, min_val;
    logic        a_neg, b_neg, div_zero, overflow, accept;

    always_comb begin
        a_sext32 = {{32{dividend[31]}}, dividend[31:0]};
        if (div_32) begin
            a_ext = div_signed ? a_sext32 : {32'b0, dividend[31:0]};
            b_ext = div_signed ? {{32{divisor[31]}}, divisor[31:0]} : {32'b0, divisor[31:0]};
            min_val = 64'hFFFF_FFFF_8000_0000;
        end else begin
            a_ext = dividend;
            b_ext = divisor;
            min_val = 64'h8000_0000_0000_0000;
        end
        a_neg    = div_signed & a_ext[63];
        b_neg    = div_signed & b_ext[63];
        a_mag    = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag    = b_neg ? (~b_ext + 64'd1) : b_ext;
        div_zero = (b_ext == 64'd0);
        overflow = div_signed & (a_ext == min_val) & (b_ext == {64{1'b1}});
        accept   = div_valid & ~flush & (state_q == IDLE);
    end

    // One restoring step: the shifted partial remainder is 65 bits wide
    logic [64:0] rem_sh;
    logic        trial_ok;
    logic [63:0] trial;

    assign rem_sh   = {rem_q, quo_q[63]};
    assign trial_ok = (rem_sh >= {1'b0, dsr_q});
    assign trial    = rem_sh[63:0] - dsr_q;

    logic [63:0] q_fix, r_fix;

    always_comb begin
        q_fix = qneg_q ? (~quo_q + 64'd1) : quo_q;
        r_fix = rneg_q ? (~rem_q + 64'd1) : rem_q;
        if (w32_q) begin
            q_fix = {{32{q_fix[31]}}, q_fix[31:0]};
            r_fix = {{32{r_fix[31]}}, r_fix[31:0]};
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no latch is inferred.
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        w32_d   = w32_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    w32_d = div_32;
                    if (div_zero) begin
                        quo_d   = {64{1'b1}};
                        rem_d   = div_32 ? a_sext32 : dividend;
                        state_d = DONE;
                    end else if (overflow) begin
                        quo_d   = div_32 ? a_sext32 : dividend;
                        rem_d   = 64'd0;
                        state_d = DONE;
                    end else begin
                        // Word operands start at the top so 32 shifts consume them
                        quo_d   = div_32 ? {a_mag[31:0], 32'b0} : a_mag;
                        rem_d   = 64'd0;
                        dsr_d   = b_mag;
                        cnt_d   = div_32 ? 7'd32 : 7'd64;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = trial_ok ? trial : rem_sh[63:0];
                quo_d = {quo_q[62:0], trial_ok};
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = FIX;
            end
            FIX: begin
                quo_d   = q_fix;
                rem_d   = r_fix;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            quo_q   <= 64'd0;
            rem_q   <= 64'd0;
            dsr_q   <= 64'd0;
            cnt_q   <= 7'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            w32_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            w32_q   <= w32_d;
        end
    end

    assign div_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
